// File: rtl/pipe_stall_ctrl.sv
// Per-stage pipeline enable generator: freezes a pipeline prefix for the
// programmed wait states of external PM/DM accesses, honours hold, counts stalls.
module pipe_stall_ctrl #(
  parameter int NSTAGE      = 4,
  parameter int ADDR_W      = 16,
  parameter int EXT_HI_BITS = 4,
  parameter int PM_STAGE    = 1,
  parameter int DM_RD_STAGE = 2,
  parameter int DM_WR_STAGE = 3,
  parameter int WS_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              pm_req,
  input  logic [ADDR_W-1:0] pm_add,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_add,
  input  logic              dm_wrb,
  input  logic [WS_W-1:0]   pm_ws,
  input  logic [WS_W-1:0]   dm_ws,
  input  logic              cnt_clr,
  output logic [NSTAGE-1:0] stage_en,
  output logic              pm_busy,
  output logic              dm_busy,
  output logic [15:0]       stall_cycles
);

  function automatic logic [NSTAGE-1:0] low_mask(input int top);
    logic [NSTAGE-1:0] m;
    for (int i = 0; i < NSTAGE; i++) m[i] = (i <= top);
    return m;
  endfunction

  localparam logic [NSTAGE-1:0] PM_MASK    = low_mask(PM_STAGE);
  localparam logic [NSTAGE-1:0] DM_RD_MASK = low_mask(DM_RD_STAGE);
  localparam logic [NSTAGE-1:0] DM_WR_MASK = low_mask(DM_WR_STAGE);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} port_st_e;

  port_st_e          pm_st_q, pm_st_d, dm_st_q, dm_st_d;
  logic [WS_W-1:0]   pm_cnt_q, pm_cnt_d, dm_cnt_q, dm_cnt_d;
  logic              dm_wr_q, dm_wr_d;
  logic [15:0]       stall_q, stall_d;
  logic              pm_hit, dm_hit, pm_frz, dm_frz, dm_wr_eff, dm_done_ok;
  logic [NSTAGE-1:0] dm_mask;

  assign pm_hit = pm_req & (|pm_add[ADDR_W-1 -: EXT_HI_BITS]);
  assign dm_hit = dm_req & (|dm_add[ADDR_W-1 -: EXT_HI_BITS]);

  // The first frozen cycle is the hit cycle itself, so freeze is decoded from IDLE too.
  assign pm_frz = (pm_st_q == WAIT) | ((pm_st_q == IDLE) & pm_hit & (|pm_ws));
  assign dm_frz = (dm_st_q == WAIT) | ((dm_st_q == IDLE) & dm_hit & (|dm_ws));

  assign dm_wr_eff  = (dm_st_q == IDLE) ? dm_wrb : dm_wr_q;
  assign dm_mask    = dm_wr_eff ? DM_WR_MASK : DM_RD_MASK;
  assign dm_done_ok = dm_wr_q ? stage_en[DM_WR_STAGE] : stage_en[DM_RD_STAGE];

  assign stage_en = rst ? '1 :
                    ~({NSTAGE{hold}} | (pm_frz ? PM_MASK : '0) | (dm_frz ? dm_mask : '0));

  assign pm_busy      = ~rst & ((pm_st_q != IDLE) | pm_frz);
  assign dm_busy      = ~rst & ((dm_st_q != IDLE) | dm_frz);
  assign stall_cycles = stall_q;

  always_comb begin
    pm_st_d  = pm_st_q;
    pm_cnt_d = pm_cnt_q;
    case (pm_st_q)
      IDLE: if (pm_frz) begin
        if (pm_ws == WS_W'(1)) pm_st_d = DONE;
        else begin
          pm_st_d  = WAIT;
          pm_cnt_d = pm_ws - WS_W'(1);
        end
      end
      WAIT: begin
        pm_cnt_d = pm_cnt_q - WS_W'(1);
        if (pm_cnt_q == WS_W'(1)) pm_st_d = DONE;
      end
      DONE: if (stage_en[PM_STAGE]) pm_st_d = IDLE;
      default: pm_st_d = IDLE;
    endcase
  end

  always_comb begin
    dm_st_d  = dm_st_q;
    dm_cnt_d = dm_cnt_q;
    dm_wr_d  = dm_wr_q;
    case (dm_st_q)
      IDLE: if (dm_frz) begin
        dm_wr_d = dm_wrb;
        if (dm_ws == WS_W'(1)) dm_st_d = DONE;
        else begin
          dm_st_d  = WAIT;
          dm_cnt_d = dm_ws - WS_W'(1);
        end
      end
      WAIT: begin
        dm_cnt_d = dm_cnt_q - WS_W'(1);
        if (dm_cnt_q == WS_W'(1)) dm_st_d = DONE;
      end
      DONE: if (dm_done_ok) dm_st_d = IDLE;
      default: dm_st_d = IDLE;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (cnt_clr) stall_d = '0;
    else if (!stage_en[0] && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pm_st_q  <= IDLE;
      dm_st_q  <= IDLE;
      pm_cnt_q <= '0;
      dm_cnt_q <= '0;
      dm_wr_q  <= 1'b0;
      stall_q  <= '0;
    end else begin
      pm_st_q  <= pm_st_d;
      dm_st_q  <= dm_st_d;
      pm_cnt_q <= pm_cnt_d;
      dm_cnt_q <= dm_cnt_d;
      dm_wr_q  <= dm_wr_d;
      stall_q  <= stall_d;
    end
  end

endmodule
